// File: rtl/signed_divider.sv
// signed_divider: 32-bit signed restoring divider, one quotient bit per cycle.
// Quotient truncates toward zero and the remainder takes the dividend's sign.
module signed_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] RegAOut,
  input  logic [31:0] RegBOut,
  input  logic        DivCtrl,
  output logic        DivDone,
  output logic        DivZero,
  output logic [31:0] DivHIOut,
  output logic [31:0] DivLOOut
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, dvs, abs_a, abs_b;
  logic        sa, sq;
  logic [32:0] sh, diff;
  assign abs_a = RegAOut[31] ? -RegAOut : RegAOut;
  assign abs_b = RegBOut[31] ? -RegBOut : RegBOut;
  // 33-bit working value: remainder shifted left with the next dividend bit
  assign sh    = {rem, quo[31]};
  assign diff  = sh - {1'b0, dvs};
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && DivCtrl) state_nx = (RegBOut == 32'd0) ? DONE : RUN;
    else if (!DivCtrl) state_nx = IDLE;
    else if (state == RUN && cnt == 6'd31) state_nx = FIX;
    else if (state == FIX) state_nx = DONE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sa       <= 1'b0;
      sq       <= 1'b0;
      DivDone  <= 1'b0;
      DivZero  <= 1'b0;
      DivHIOut <= '0;
      DivLOOut <= '0;
    end else if (state == IDLE && DivCtrl) begin
      quo <= abs_a;
      dvs <= abs_b;
      sa  <= RegAOut[31];
      sq  <= RegAOut[31] ^ RegBOut[31];
      cnt <= '0;
      rem <= '0;
      if (RegBOut == 32'd0) begin
        DivDone <= 1'b1;
        DivZero <= 1'b1;
      end
    end else if (state == RUN && DivCtrl) begin
      rem <= diff[32] ? sh[31:0] : diff[31:0];
      quo <= {quo[30:0], ~diff[32]};
      cnt <= cnt + 6'd1;
    end else if (state == FIX && DivCtrl) begin
      DivLOOut <= sq ? -quo : quo;
      DivHIOut <= sa ? -rem : rem;
      DivDone  <= 1'b1;
    end else if (state == DONE && !DivCtrl) begin
      DivDone <= 1'b0;
      DivZero <= 1'b0;
    end
endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: directed and random division checked against an arithmetic model.
module tb_signed_divider;
  logic        clock = 1'b0, reset = 1'b0, DivCtrl = 1'b0;
  logic [31:0] RegAOut = '0, RegBOut = '0;
  logic        DivDone, DivZero;
  logic [31:0] DivHIOut, DivLOOut;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] hi_m = '0, lo_m = '0;
  signed_divider dut (
    .clock(clock), .reset(reset), .RegAOut(RegAOut), .RegBOut(RegBOut),
    .DivCtrl(DivCtrl), .DivDone(DivDone), .DivZero(DivZero),
    .DivHIOut(DivHIOut), .DivLOOut(DivLOOut)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // 64-bit signed arithmetic truncates toward zero; 2^31 wraps to 0x80000000
  task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] q, output logic [31:0] r);
    longint la, lb;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    q = 32'(la / lb);
    r = 32'(la % lb);
  endtask
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] q, r;
    if (b != 32'd0) model(a, b, q, r);
    @(negedge clock);
    RegAOut = a;
    RegBOut = b;
    DivCtrl = 1'b1;
    @(posedge clock); #1;
    RegAOut = $urandom;
    RegBOut = $urandom;
    if (b == 32'd0) begin
      check({tag, " zero"}, {31'b0, DivZero}, 32'd1);
      check({tag, " done"}, {31'b0, DivDone}, 32'd1);
      check({tag, " hi kept"}, DivHIOut, hi_m);
      check({tag, " lo kept"}, DivLOOut, lo_m);
    end else begin
      repeat (32) @(posedge clock);
      #1 check({tag, " early done"}, {31'b0, DivDone}, 32'd0);
      @(posedge clock);
      #1 check({tag, " done"}, {31'b0, DivDone}, 32'd1);
      check({tag, " zero"}, {31'b0, DivZero}, 32'd0);
      check({tag, " lo"}, DivLOOut, q);
      check({tag, " hi"}, DivHIOut, r);
      hi_m = r;
      lo_m = q;
    end
    @(posedge clock);
    #1 check({tag, " hold done"}, {31'b0, DivDone}, 32'd1);
    @(negedge clock) DivCtrl = 1'b0;
    @(posedge clock); #1;
    check({tag, " clr done"}, {31'b0, DivDone}, 32'd0);
    check({tag, " clr zero"}, {31'b0, DivZero}, 32'd0);
    check({tag, " hi after"}, DivHIOut, hi_m);
    check({tag, " lo after"}, DivLOOut, lo_m);
  endtask
  initial begin
    #12;
    check("rst done", {31'b0, DivDone}, 32'd0);
    check("rst zero", {31'b0, DivZero}, 32'd0);
    check("rst hi", DivHIOut, 32'd0);
    check("rst lo", DivLOOut, 32'd0);
    @(negedge clock) reset = 1'b1;
    do_div(32'd7, 32'd2, "7/2");
    check("7/2 lo const", lo_m, 32'h3);
    check("7/2 hi const", hi_m, 32'h1);
    do_div(32'hFFFFFFF9, 32'd2, "-7/2");
    do_div(32'd7, 32'hFFFFFFFE, "7/-2");
    do_div(32'h12345678, 32'd0, "div0");
    do_div(32'h80000000, 32'hFFFFFFFF, "ovf");
    check("ovf lo const", DivLOOut, 32'h80000000);
    check("ovf hi const", DivHIOut, 32'h0);
    @(negedge clock);
    RegAOut = 32'd100;
    RegBOut = 32'd7;
    DivCtrl = 1'b1;
    repeat (11) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("async rst hi", DivHIOut, 32'd0);
    check("async rst lo", DivLOOut, 32'd0);
    check("async rst done", {31'b0, DivDone}, 32'd0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clock);
    DivCtrl = 1'b0;
    reset = 1'b1;
    do_div(32'd100, 32'd7, "100/7");
    check("100/7 lo const", lo_m, 32'd14);
    do_div(32'hFFFFFF00, 32'd9, "pre abort");
    @(negedge clock);
    RegAOut = 32'd100;
    RegBOut = 32'd7;
    DivCtrl = 1'b1;
    repeat (21) @(posedge clock);
    @(negedge clock) DivCtrl = 1'b0;
    @(posedge clock);
    #1 check("abort done", {31'b0, DivDone}, 32'd0);
    repeat (40) @(posedge clock);
    #1 check("abort idle done", {31'b0, DivDone}, 32'd0);
    check("abort hi", DivHIOut, hi_m);
    check("abort lo", DivLOOut, lo_m);
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = (i % 5 == 0) ? 32'h80000000 : $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if (i % 4 == 1) b = -b;
      do_div(a, b, $sformatf("rnd%0d", i));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and reset as in the rest of the datapath.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- RegAOut  input  32  dividend, two's complement
- RegBOut  input  32  divisor, two's complement
- DivCtrl  input  1  start/hold request from the control unit
- DivDone  output  1  result valid
- DivZero  output  1  divide-by-zero exception flag
- DivHIOut  output  32  remainder
- DivLOOut  output  32  quotient
REQ-003 Parameters: none; all widths are fixed at 32 bits.

Function
REQ-004 The block SHALL be a four-state FSM:
- IDLE: waiting for a request.
- RUN: 32 restoring-division iterations.
- FIX: sign correction and result write.
- DONE: holding the result.
REQ-005 In IDLE, DivCtrl=1 sampled at a rising edge SHALL trigger capture on that edge:
- store |RegAOut|, |RegBOut|, sign(A) and sign(A) XOR sign(B);
- clear the 6-bit iteration counter and the 33-bit partial remainder;
- go to RUN.
REQ-006 If RegBOut=0 at capture, the block SHALL instead go directly to DONE with DivZero=1 and DivDone=1.
- DivHIOut and DivLOOut keep their previous values.
- Latency is 1 edge.
REQ-007 Each RUN cycle SHALL perform one restoring step:
- shift {remainder, quotient} left by 1, moving the dividend MSB into the remainder;
- subtract |divisor| (33-bit);
- if the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore the remainder and set the quotient LSB to 0;
- increment the counter.
REQ-008 After exactly 32 RUN cycles the FSM SHALL go to FIX.
REQ-009 In FIX, on one edge, the block SHALL:
- negate the quotient if the result-sign bit is 1;
- negate the remainder if sign(A) is 1;
- write the quotient to DivLOOut and the remainder to DivHIOut;
- set DivDone=1 and go to DONE.
REQ-010 Total latency from the capture edge to DivDone=1 SHALL be 34 rising edges: 1 capture + 32 RUN + 1 FIX.
REQ-011 The quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend, with |remainder| < |divisor|.
REQ-012 Absolute values SHALL be formed as 32-bit unsigned, so |0x80000000| = 2^31.
REQ-013 The overflow case 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0x00000000 with no flag.
REQ-014 In DONE, DivDone, DivZero, DivHIOut and DivLOOut SHALL hold while DivCtrl=1.
REQ-015 In DONE, DivCtrl=0 SHALL return the FSM to IDLE on the next edge and clear DivDone and DivZero; DivHIOut and DivLOOut keep their values.
REQ-016 DivCtrl=0 during RUN or FIX SHALL abort the operation: go to IDLE on the next edge with DivHIOut and DivLOOut unchanged and DivDone=0.
REQ-017 RegAOut and RegBOut SHALL be sampled only at the capture edge; changes afterwards SHALL NOT affect the result.
REQ-018 A new operation SHALL require DivCtrl to be low for at least one edge after DONE (no back-to-back restart from DONE).
REQ-019 DivDone and DivZero SHALL be registered outputs with no combinational path from any input.

Reset
REQ-020 reset=0 SHALL asynchronously force:
- the FSM to IDLE;
- DivDone=0 and DivZero=0;
- DivHIOut=0 and DivLOOut=0;
- the counter and all internal operand/remainder registers to 0.
REQ-021 reset asserted mid-operation SHALL discard the operation, with no result written.
REQ-022 After reset is released, the first rising edge with DivCtrl=1 SHALL be treated as a capture edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- A=7, B=2, DivCtrl held high -> at edge 34, DivDone=1, LO=0x00000003, HI=0x00000001, DivZero=0.
- A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also A=7, B=-2 -> LO=0xFFFFFFFD, HI=0x00000001.
- A=0x12345678, B=0 -> after 1 edge, DivZero=1 and DivDone=1, HI and LO unchanged. Then drop DivCtrl -> both flags clear on the next edge.
- A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, DivZero=0.
- Start 100/7, assert reset=0 at RUN cycle 10 (asynchronous) -> outputs read 0 immediately. Release reset and restart -> LO=14, HI=2 at edge 34.
- Start 100/7, drop DivCtrl at RUN cycle 20 -> IDLE next edge, DivDone stays 0, prior HI/LO retained.
